bd_sync_sink: RTL and testbench

- Synchronous consumer for the right-hand 4-phase bundled-data channel (Rreq/Rack/Rdata) of the last resilient pipeline stage.
- Synchronizes Rreq, captures Rdata into a small FIFO, and returns Rack.
- Presents tokens on a valid/ready interface.
- Maintains token, stall and inter-token gap statistics for throughput measurement of the asynchronous pipeline.

---
 rtl/bd_pkg.sv | 18 +
 rtl/bd_sync_fifo.sv | 60 ++++++
 rtl/bd_sync_sink.sv | 135 +++++++++++++
 tb/tb_bd_sync_sink.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bd_pkg.sv
// Shared types and defaults for the bundled-data sink.
package bd_pkg;

    localparam int BD_DATA_WIDTH  = 8;
    localparam int BD_SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STALL = 2'd1,
        ACK   = 2'd2
    } sink_state_t;

    // Occupancy counter width: must be able to represent a completely full buffer.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/bd_sync_fifo.sv
// Token buffer between the handshake FSM and the valid/ready consumer.
module bd_sync_fifo
    import bd_pkg::*;
#(
    parameter  int DATA_WIDTH = BD_DATA_WIDTH,
    parameter  int FIFO_DEPTH = 4,
    localparam int PTR_W      = $clog2(FIFO_DEPTH),
    localparam int CNT_W      = count_width(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [CNT_W-1:0]      count_o
);

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q;
    logic [PTR_W-1:0]      rd_ptr_q;
    logic [CNT_W-1:0]      count_q;
    logic                  do_push;
    logic                  do_pop;

    assign full_o  = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wr_data_i;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    assign rd_data_o = mem_q[rd_ptr_q];
    assign count_o   = count_q;

endmodule

// File: rtl/bd_sync_sink.sv
// Synchronous sink for a 4-phase bundled-data channel with throughput statistics.
//   state | meaning
//   IDLE  | waiting for a synchronized request
//   STALL | request pending, buffer full, counting stall cycles
//   ACK   | token captured, Rack high, waiting for request to return low
module bd_sync_sink
    import bd_pkg::*;
#(
    parameter  int DATA_WIDTH  = BD_DATA_WIDTH,
    parameter  int FIFO_DEPTH  = 4,
    parameter  int SYNC_STAGES = BD_SYNC_STAGES,
    parameter  int CNT_WIDTH   = 32,
    localparam int FCW         = count_width(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  Rreq,
    input  logic [DATA_WIDTH-1:0] Rdata,
    output logic                  Rack,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [FCW-1:0]        fifo_count,
    output logic [CNT_WIDTH-1:0]  token_count,
    output logic [CNT_WIDTH-1:0]  stall_count,
    output logic [CNT_WIDTH-1:0]  last_gap
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   req_s;
    sink_state_t            state_q;
    logic                   rack_q;
    logic [CNT_WIDTH-1:0]   token_cnt_q;
    logic [CNT_WIDTH-1:0]   stall_cnt_q;
    logic [CNT_WIDTH-1:0]   gap_cnt_q;
    logic [CNT_WIDTH-1:0]   last_gap_q;
    logic                   seen_q;
    logic                   full;
    logic                   empty;
    logic                   capture;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], Rreq};
        end
    end

    assign req_s = sync_q[SYNC_STAGES-1];

    // Full is the pre-edge value, so a same-edge pop never lets a stalled token through.
    always_comb begin
        capture = 1'b0;
        if (!full) begin
            capture = (state_q == STALL) || ((state_q == IDLE) && req_s);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            rack_q      <= 1'b0;
            token_cnt_q <= '0;
            stall_cnt_q <= '0;
            gap_cnt_q   <= '0;
            last_gap_q  <= '0;
            seen_q      <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (capture) begin
                        rack_q  <= 1'b1;
                        state_q <= ACK;
                    end else if (req_s) begin
                        state_q <= STALL;
                    end
                end
                STALL: begin
                    if (stall_cnt_q != CNT_MAX) begin
                        stall_cnt_q <= stall_cnt_q + CNT_WIDTH'(1);
                    end
                    if (capture) begin
                        rack_q  <= 1'b1;
                        state_q <= ACK;
                    end
                end
                ACK: begin
                    if (!req_s) begin
                        rack_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    rack_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase

            // Gap counter restarts at 1 so the next capture reports the edge distance.
            if (capture) begin
                token_cnt_q <= token_cnt_q + CNT_WIDTH'(1);
                gap_cnt_q   <= CNT_WIDTH'(1);
                last_gap_q  <= seen_q ? gap_cnt_q : '0;
                seen_q      <= 1'b1;
            end else if (gap_cnt_q != CNT_MAX) begin
                gap_cnt_q <= gap_cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    bd_sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst),
        .push_i    (capture),
        .wr_data_i (Rdata),
        .pop_i     (out_ready),
        .rd_data_o (out_data),
        .full_o    (full),
        .empty_o   (empty),
        .count_o   (fifo_count)
    );

    assign Rack        = rack_q;
    assign out_valid   = !empty;
    assign token_count = token_cnt_q;
    assign stall_count = stall_cnt_q;
    assign last_gap    = last_gap_q;

endmodule

// File: tb/tb_bd_sync_sink.sv
// Scenario bench for bd_sync_sink with a data scoreboard on the valid/ready side.
module tb_bd_sync_sink;

    localparam int DW = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          Rreq;
    logic [DW-1:0] Rdata;
    logic          Rack;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [2:0]    fifo_count;
    logic [CW-1:0] token_count;
    logic [CW-1:0] stall_count;
    logic [CW-1:0] last_gap;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] exp_d;

    always #5 clk = ~clk;

    bd_sync_sink #(
        .DATA_WIDTH  (DW),
        .FIFO_DEPTH  (4),
        .SYNC_STAGES (2),
        .CNT_WIDTH   (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .Rreq        (Rreq),
        .Rdata       (Rdata),
        .Rack        (Rack),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .fifo_count  (fifo_count),
        .token_count (token_count),
        .stall_count (stall_count),
        .last_gap    (last_gap)
    );

    // One clock cycle; any pop happening on the coming edge is scored at the negedge.
    task automatic tick();
        @(negedge clk);
        if (rst && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_pop: got %0h with nothing expected", out_data);
            end else begin
                exp_d = exp_q.pop_front();
                if (out_data !== exp_d) begin
                    errors++;
                    $display("FAIL sb_data: got %0h expected %0h", out_data, exp_d);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_rack(input logic lvl, input int budget);
        int n = 0;
        while (Rack !== lvl && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (Rack !== lvl) begin
            errors++;
            $display("FAIL rack_wait: got %b expected %b", Rack, lvl);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; Rreq = 1'b0; Rdata = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (Rack !== 1'b0) begin errors++; $display("FAIL rst_rack: got %b expected 0", Rack); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", out_valid); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL rst_data: got %0h expected 0", out_data); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL rst_count: got %0d expected 0", fifo_count); end
        checks++; if ({token_count, stall_count, last_gap} !== 12'h000) begin
            errors++; $display("FAIL rst_counters: got %0h/%0h/%0h expected 0", token_count, stall_count, last_gap);
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_single();
        Rdata = 8'hA5; Rreq = 1'b1; exp_q.push_back(8'hA5);
        tick_n(2);
        checks++; if (Rack !== 1'b0) begin errors++; $display("FAIL single_early_rack: got %b expected 0", Rack); end
        tick();
        checks++; if (Rack !== 1'b1) begin errors++; $display("FAIL single_rack: got %b expected 1", Rack); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", out_valid); end
        checks++; if (out_data !== 8'hA5) begin errors++; $display("FAIL single_data: got %0h expected a5", out_data); end
        checks++; if (token_count !== 4'd1) begin errors++; $display("FAIL single_tokens: got %0d expected 1", token_count); end
        checks++; if (last_gap !== 4'd0) begin errors++; $display("FAIL single_gap: got %0d expected 0", last_gap); end
        Rreq = 1'b0;
        tick_n(2);
        checks++; if (Rack !== 1'b1) begin errors++; $display("FAIL single_rack_hold: got %b expected 1", Rack); end
        tick();
        checks++; if (Rack !== 1'b0) begin errors++; $display("FAIL single_rack_fall: got %b expected 0", Rack); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0 || fifo_count !== 3'd0) begin
            errors++; $display("FAIL single_drain: got valid %b count %0d expected 0/0", out_valid, fifo_count);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            Rdata = 8'(i); Rreq = 1'b1; exp_q.push_back(8'(i));
            wait_rack(1'b1, 8);
            Rreq = 1'b0;
            wait_rack(1'b0, 8);
        end
        checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL bp_full: got %0d expected 4", fifo_count); end
        Rdata = 8'h05; Rreq = 1'b1; exp_q.push_back(8'h05);
        tick_n(6);
        checks++; if (Rack !== 1'b0) begin errors++; $display("FAIL bp_stall_rack: got %b expected 0", Rack); end
        checks++; if (stall_count !== 4'd3) begin errors++; $display("FAIL bp_stall_cnt: got %0d expected 3", stall_count); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++; if (fifo_count !== 3'd3 || Rack !== 1'b0) begin
            errors++; $display("FAIL bp_no_bypass: got count %0d rack %b expected 3/0", fifo_count, Rack);
        end
        tick();
        checks++; if (Rack !== 1'b1 || fifo_count !== 3'd4) begin
            errors++; $display("FAIL bp_release: got rack %b count %0d expected 1/4", Rack, fifo_count);
        end
        checks++; if (stall_count !== 4'd5) begin errors++; $display("FAIL bp_stall_final: got %0d expected 5", stall_count); end
        Rreq = 1'b0;
        wait_rack(1'b0, 8);
        out_ready = 1'b1;
        tick_n(4);
        out_ready = 1'b0;
        checks++; if (exp_q.size() != 0 || fifo_count !== 3'd0) begin
            errors++; $display("FAIL bp_drain: got left %0d count %0d expected 0/0", exp_q.size(), fifo_count);
        end
        checks++; if (token_count !== 4'd6) begin errors++; $display("FAIL bp_tokens: got %0d expected 6", token_count); end
    endtask

    task automatic test_simul_push_pop();
        out_ready = 1'b0;
        for (int i = 1; i <= 2; i++) begin
            Rdata = 8'(i * 8'h11); Rreq = 1'b1; exp_q.push_back(8'(i * 8'h11));
            wait_rack(1'b1, 8);
            Rreq = 1'b0;
            wait_rack(1'b0, 8);
        end
        Rdata = 8'h33; Rreq = 1'b1; exp_q.push_back(8'h33);
        tick_n(2);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++; if (fifo_count !== 3'd2 || Rack !== 1'b1) begin
            errors++; $display("FAIL pp_count: got count %0d rack %b expected 2/1", fifo_count, Rack);
        end
        Rreq = 1'b0;
        wait_rack(1'b0, 8);
        out_ready = 1'b1;
        tick_n(2);
        out_ready = 1'b0;
        checks++; if (exp_q.size() != 0 || fifo_count !== 3'd0) begin
            errors++; $display("FAIL pp_drain: got left %0d count %0d expected 0/0", exp_q.size(), fifo_count);
        end
    endtask

    task automatic test_gap();
        out_ready = 1'b1;
        Rdata = 8'h44; Rreq = 1'b1; exp_q.push_back(8'h44);
        tick_n(3);
        Rreq = 1'b0;
        tick_n(7);
        Rdata = 8'h55; Rreq = 1'b1; exp_q.push_back(8'h55);
        tick_n(3);
        checks++; if (Rack !== 1'b1 || last_gap !== 4'd10) begin
            errors++; $display("FAIL gap_10: got rack %b gap %0d expected 1/10", Rack, last_gap);
        end
        Rreq = 1'b0;
        tick_n(4);
        Rdata = 8'h66; Rreq = 1'b1; exp_q.push_back(8'h66);
        tick_n(3);
        checks++; if (Rack !== 1'b1 || last_gap !== 4'd7) begin
            errors++; $display("FAIL gap_7: got rack %b gap %0d expected 1/7", Rack, last_gap);
        end
        Rreq = 1'b0;
        tick_n(20);
        Rdata = 8'h77; Rreq = 1'b1; exp_q.push_back(8'h77);
        tick_n(3);
        checks++; if (Rack !== 1'b1 || last_gap !== 4'd15) begin
            errors++; $display("FAIL gap_sat: got rack %b gap %0d expected 1/15", Rack, last_gap);
        end
        Rreq = 1'b0;
        wait_rack(1'b0, 8);
        tick();
        out_ready = 1'b0;
        checks++; if (exp_q.size() != 0 || fifo_count !== 3'd0) begin
            errors++; $display("FAIL gap_drain: got left %0d count %0d expected 0/0", exp_q.size(), fifo_count);
        end
        checks++; if (token_count !== 4'd13) begin errors++; $display("FAIL gap_tokens: got %0d expected 13", token_count); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        Rdata = 8'h9A; Rreq = 1'b1;
        tick_n(3);
        checks++; if (Rack !== 1'b1 || fifo_count !== 3'd1) begin
            errors++; $display("FAIL rm_ack: got rack %b count %0d expected 1/1", Rack, fifo_count);
        end
        #2 rst = 1'b0;
        #1;
        checks++; if (Rack !== 1'b0 || fifo_count !== 3'd0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL rm_async: got rack %b count %0d valid %b expected 0/0/0", Rack, fifo_count, out_valid);
        end
        checks++; if ({token_count, stall_count, last_gap} !== 12'h000) begin
            errors++; $display("FAIL rm_counters: got %0h/%0h/%0h expected 0", token_count, stall_count, last_gap);
        end
        exp_q.delete();
        exp_q.push_back(8'h9A);
        tick();
        rst = 1'b1;
        tick_n(2);
        checks++; if (Rack !== 1'b0) begin errors++; $display("FAIL rm_early: got %b expected 0", Rack); end
        tick();
        checks++; if (Rack !== 1'b1 || token_count !== 4'd1 || out_data !== 8'h9A) begin
            errors++; $display("FAIL rm_recapture: got rack %b tokens %0d data %0h expected 1/1/9a", Rack, token_count, out_data);
        end
        Rreq = 1'b0;
        wait_rack(1'b0, 8);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rm_drain: got left %0d expected 0", exp_q.size()); end
    endtask

    task automatic test_rreq_high_reset();
        out_ready = 1'b0;
        rst = 1'b0;
        Rdata = 8'h3C; Rreq = 1'b1;
        exp_q.delete();
        exp_q.push_back(8'h3C);
        tick_n(2);
        rst = 1'b1;
        tick_n(2);
        checks++; if (Rack !== 1'b0) begin errors++; $display("FAIL rh_early: got %b expected 0", Rack); end
        tick();
        checks++; if (Rack !== 1'b1 || out_data !== 8'h3C || token_count !== 4'd1) begin
            errors++; $display("FAIL rh_capture: got rack %b data %0h tokens %0d expected 1/3c/1", Rack, out_data, token_count);
        end
        Rreq = 1'b0;
        wait_rack(1'b0, 8);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++; if (exp_q.size() != 0 || fifo_count !== 3'd0) begin
            errors++; $display("FAIL rh_drain: got left %0d count %0d expected 0/0", exp_q.size(), fifo_count);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_simul_push_pop();
        test_gap();
        test_reset_mid();
        test_rreq_high_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
